mem_port_arbiter: RTL

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-memory (load/store) port. It sits between the IF and MEM stages and the memory macro. It serialises accesses with a request/grant/valid handshake, gives the data port priority with a starvation guard for fetch, and drives stall signals consumed by the pipeline's existing stall/hazard logic.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// and the default fetch starvation limit.
package rv32i_pkg;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned STREAK_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle around the shared memory port.
// master is the arbiter's view; slave is the pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;

    logic              stall_if;
    logic              stall_mem;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Owner selection: data port wins contention unless fetch has waited
// through STARVE_LIMIT consecutive data grants.
module mem_arb_pick
    import rv32i_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                any_req_c,
    output arb_owner_t          owner_c
);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    always_comb begin
        any_req_c = if_req | dm_req;
        owner_c   = OWN_DM;
        if (if_req && (!dm_req || streak == LIMIT)) begin
            owner_c = OWN_IF;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-ported
// memory, one outstanding transaction at a time.
module mem_port_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    mem_port_arbiter_if.master   bus
);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    arb_state_t          state;
    arb_owner_t          owner;
    logic [STREAK_W-1:0] streak;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                if_valid_q;
    logic                dm_valid_q;

    logic                any_req_c;
    arb_owner_t          pick_c;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .if_req    (bus.if_req),
        .dm_req    (bus.dm_req),
        .streak    (streak),
        .any_req_c (any_req_c),
        .owner_c   (pick_c)
    );

    // Transaction FSM; valid pulses are raised on entry to DONE and cleared by default.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            streak      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        owner       <= pick_c;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= (pick_c == OWN_DM) ? bus.dm_addr : bus.if_addr;
                        mem_wdata_q <= (pick_c == OWN_DM) ? bus.dm_wdata : '0;
                        mem_we_q    <= (pick_c == OWN_DM) && bus.dm_we;
                        if (pick_c == OWN_IF) begin
                            streak <= '0;
                        end else if (bus.if_req && streak != LIMIT) begin
                            streak <= streak + 1'b1;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            dm_valid_q <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.mem_rvalid) begin
                        if (owner == OWN_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            dm_rdata_q <= bus.mem_rdata;
                            dm_valid_q <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_valid  = dm_valid_q;

    // Stalls follow the requester's own req so a dropped request never stalls.
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_mem = bus.dm_req & ~dm_valid_q;
endmodule
